// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: input stream, perceptron control/replay, output stream and status of one layer sequencer.
interface layer_sequencer_if #(
  parameter int DATA_W  = 32,
  parameter int WADDR_W = 12
);
  logic [DATA_W-1:0]  in_tdata;
  logic               in_tvalid;
  logic               in_tready;
  logic               in_tlast;
  logic               pe_start;
  logic [WADDR_W-1:0] pe_weight_base;
  logic [DATA_W-1:0]  pe_x_tdata;
  logic               pe_x_tvalid;
  logic               pe_x_tready;
  logic [DATA_W-1:0]  pe_a_tdata;
  logic               pe_done;
  logic [DATA_W-1:0]  out_tdata;
  logic               out_tvalid;
  logic               out_tready;
  logic               out_tlast;
  logic               busy;
  logic               err_len;
  logic               err_timeout;
  logic               err_clr;
  modport master (
    input  in_tdata, in_tvalid, in_tlast, pe_x_tready, pe_a_tdata, pe_done, out_tready, err_clr,
    output in_tready, pe_start, pe_weight_base, pe_x_tdata, pe_x_tvalid,
           out_tdata, out_tvalid, out_tlast, busy, err_len, err_timeout
  );
  modport slave (
    output in_tdata, in_tvalid, in_tlast, pe_x_tready, pe_a_tdata, pe_done, out_tready, err_clr,
    input  in_tready, pe_start, pe_weight_base, pe_x_tdata, pe_x_tvalid,
           out_tdata, out_tvalid, out_tlast, busy, err_len, err_timeout
  );
endinterface

// File: rtl/layer_sequencer.sv
// layer_sequencer: buffers one input vector and replays it through a shared perceptron once per neuron.
module layer_sequencer #(
  parameter int DATA_W      = 32,
  parameter int NUM_INPUTS  = 5,
  parameter int NUM_NEURONS = 10,
  parameter int WADDR_W     = 12,
  parameter int TIMEOUT     = 1024
) (
  input logic s_axi_aclk,
  input logic s_axi_areset,
  layer_sequencer_if.master bus
);
  localparam int IW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
  localparam int NW = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [WADDR_W-1:0] STEP = WADDR_W'(NUM_INPUTS * 4);
  if (NUM_NEURONS * NUM_INPUTS * 4 > 2 ** WADDR_W) begin : g_bad_waddr
    $error("layer_sequencer: weight banks do not fit in WADDR_W");
  end
  typedef enum logic [2:0] {LOAD, START, FEED, WAIT, EMIT} state_t;
  state_t state, nxt;
  logic [DATA_W-1:0]  vec [NUM_INPUTS];
  logic [IW-1:0]      wcnt, rcnt;
  logic [NW-1:0]      neuron;
  logic [TW-1:0]      tmr;
  logic [WADDR_W-1:0] base;
  logic [DATA_W-1:0]  out_q;
  logic               err_len_q, err_tmo_q;
  logic               in_hs, x_hs, out_hs, last_w, last_r, last_n, tmr_end, len_bad, tmo_set;
  assign in_hs   = state == LOAD && bus.in_tvalid;
  assign x_hs    = state == FEED && bus.pe_x_tready;
  assign out_hs  = state == EMIT && bus.out_tready;
  assign last_w  = wcnt == IW'(NUM_INPUTS - 1);
  assign last_r  = rcnt == IW'(NUM_INPUTS - 1);
  assign last_n  = neuron == NW'(NUM_NEURONS - 1);
  assign tmr_end = tmr == TW'(TIMEOUT - 1);
  // a short vector (early tlast) and a missing tlast on the final element are both length errors
  assign len_bad = in_hs && (last_w != bus.in_tlast);
  assign tmo_set = state == WAIT && !bus.pe_done && tmr_end;
  assign bus.in_tready      = state == LOAD;
  assign bus.pe_start       = state == START;
  assign bus.pe_x_tvalid    = state == FEED;
  assign bus.pe_x_tdata     = vec[rcnt];
  assign bus.pe_weight_base = base;
  assign bus.out_tdata      = out_q;
  assign bus.out_tvalid     = state == EMIT;
  assign bus.out_tlast      = state == EMIT && last_n;
  assign bus.busy           = state != LOAD;
  assign bus.err_len        = err_len_q;
  assign bus.err_timeout    = err_tmo_q;
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset)
    if (s_axi_areset) state <= LOAD;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      LOAD:    nxt = in_hs && last_w ? START : LOAD;
      START:   nxt = FEED;
      FEED:    nxt = x_hs && last_r ? WAIT : FEED;
      WAIT:    nxt = bus.pe_done || tmr_end ? EMIT : WAIT;
      EMIT:    nxt = !bus.out_tready ? EMIT : last_n ? LOAD : START;
      default: nxt = LOAD;
    endcase
  end
  always_ff @(posedge s_axi_aclk)
    if (in_hs) vec[wcnt] <= bus.in_tdata;
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset)
    if (s_axi_areset) begin
      wcnt      <= '0;
      rcnt      <= '0;
      neuron    <= '0;
      tmr       <= '0;
      base      <= '0;
      out_q     <= '0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      if (in_hs) wcnt <= last_w || bus.in_tlast ? '0 : wcnt + 1'b1;
      if (state == START) rcnt <= '0;
      else if (x_hs && !last_r) rcnt <= rcnt + 1'b1;
      tmr <= state == WAIT ? tmr + 1'b1 : '0;
      if (state == WAIT && (bus.pe_done || tmr_end)) out_q <= bus.pe_done ? bus.pe_a_tdata : '0;
      if (in_hs && last_w) begin
        neuron <= '0;
        base   <= '0;
      end else if (out_hs && !last_n) begin
        neuron <= neuron + 1'b1;
        base   <= base + STEP;
      end
      err_len_q <= !bus.err_clr && (err_len_q || len_bad);
      err_tmo_q <= !bus.err_clr && (err_tmo_q || tmo_set);
    end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: vector table for whole-layer runs plus hand sequences for timeout, error clear and reset.
module tb_layer_sequencer;
  localparam int NI = 5, NN = 2, TO = 16;
  logic clk = 0, rst = 1;
  initial forever #5 clk = ~clk;
  layer_sequencer_if #(.DATA_W(32), .WADDR_W(12)) bus ();
  layer_sequencer #(.DATA_W(32), .NUM_INPUTS(NI), .NUM_NEURONS(NN), .WADDR_W(12), .TIMEOUT(TO)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst), .bus(bus)
  );
  typedef struct {
    int len; int tlast_at; bit stall; int hold; bit no_done; bit clr;
    int n_out; int d0; int d1; bit e_len; bit e_tmo;
  } row_t;
  int passed = 0, total = 0, cyc = 0, starts = 0, tmo_rise = -1, hold_cfg = 0;
  int bases[$], outs_d[$], entries[$];
  bit outs_l[$];
  bit stall = 0, no_done = 0;
  int acc, xi, nrn, dcnt, hold_left;
  bit tog, prev_xs, prev_os, prev_tmo;
  logic [31:0] prev_x, prev_o;
  initial forever @(posedge clk) cyc++;
  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  // perceptron model: weight of element i for neuron n is n+i+1, result is sum(x*w)+1
  initial begin
    bus.pe_x_tready = 1; bus.pe_done = 0; bus.pe_a_tdata = 0; bus.out_tready = 1;
    acc = 0; xi = 0; nrn = 0; dcnt = 0; hold_left = 0; tog = 1; prev_xs = 0; prev_os = 0; prev_tmo = 0;
    prev_x = 0; prev_o = 0;
    forever begin
      @(negedge clk); #1;
      bus.pe_done = 0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0 && !no_done) begin bus.pe_done = 1; bus.pe_a_tdata = 32'(acc + 1); end
      end
      if (bus.pe_start) begin
        starts++; bases.push_back(int'(bus.pe_weight_base));
        nrn = int'(bus.pe_weight_base) / (NI * 4); acc = 0; xi = 0;
      end
      bus.pe_x_tready = stall ? tog : 1'b1;
      tog = !tog;
      if (bus.pe_x_tvalid) begin
        if (prev_xs) check("x_stable", bus.pe_x_tdata, prev_x);
        if (bus.pe_x_tready) begin
          acc += int'(bus.pe_x_tdata) * (nrn + xi + 1);
          xi++;
          if (xi == NI) begin dcnt = 2; entries.push_back(cyc + 1); end
        end
      end
      prev_xs = bus.pe_x_tvalid && !bus.pe_x_tready; prev_x = bus.pe_x_tdata;
      if (!bus.out_tvalid) hold_left = hold_cfg;
      bus.out_tready = !(bus.out_tvalid && hold_left > 0);
      if (bus.out_tvalid) begin
        if (prev_os) check("out_hold", bus.out_tdata, prev_o);
        if (hold_left > 0) hold_left--;
        else begin outs_d.push_back(int'(bus.out_tdata)); outs_l.push_back(bus.out_tlast); end
      end
      prev_os = bus.out_tvalid && !bus.out_tready; prev_o = bus.out_tdata;
      if (bus.err_timeout && !prev_tmo && tmo_rise < 0) tmo_rise = cyc;
      prev_tmo = bus.err_timeout;
    end
  end
  task automatic clear_log();
    starts = 0; tmo_rise = -1;
    bases.delete(); outs_d.delete(); outs_l.delete(); entries.delete();
  endtask
  task automatic send_vec(input int n, input int tlast_at);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      bus.in_tdata = 32'(i + 1); bus.in_tvalid = 1; bus.in_tlast = i == tlast_at;
      while (!bus.in_tready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) check("in_accept", bus.in_tready, 1);
      @(negedge clk);
    end
    bus.in_tvalid = 0; bus.in_tlast = 0;
  endtask
  task automatic pulse_clr();
    bus.err_clr = 1; @(negedge clk); bus.err_clr = 0;
  endtask
  task automatic run_row(input row_t r, input int id);
    int t = 0;
    if (r.clr) pulse_clr();
    clear_log();
    stall = r.stall; hold_cfg = r.hold; no_done = r.no_done;
    send_vec(r.len, r.tlast_at);
    while (outs_d.size() < r.n_out && t < 1000) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    check($sformatf("r%0d_n_out", id), outs_d.size(), r.n_out);
    for (int i = 0; i < outs_d.size() && i < r.n_out; i++) begin
      check($sformatf("r%0d_data%0d", id, i), outs_d[i], i == 0 ? r.d0 : r.d1);
      check($sformatf("r%0d_last%0d", id, i), outs_l[i], i == r.n_out - 1);
    end
    check($sformatf("r%0d_starts", id), starts, r.n_out);
    for (int i = 0; i < bases.size(); i++) check($sformatf("r%0d_base%0d", id, i), bases[i], i * NI * 4);
    check($sformatf("r%0d_busy", id), bus.busy, 0);
    check($sformatf("r%0d_err_len", id), bus.err_len, r.e_len);
    check($sformatf("r%0d_err_tmo", id), bus.err_timeout, r.e_tmo);
  endtask
  initial begin
    row_t rows[6];
    int t;
    rows[0] = '{5,  4, 0, 0, 0, 0, 2, 56, 71, 0, 0};
    rows[1] = '{5,  4, 1, 5, 0, 0, 2, 56, 71, 0, 0};
    rows[2] = '{3,  2, 0, 0, 0, 0, 0,  0,  0, 1, 0};
    rows[3] = '{5,  4, 0, 0, 0, 0, 2, 56, 71, 1, 0};
    rows[4] = '{5, -1, 0, 0, 0, 0, 2, 56, 71, 1, 0};
    rows[5] = '{5,  4, 0, 0, 1, 1, 2,  0,  0, 0, 1};
    bus.in_tdata = 0; bus.in_tvalid = 0; bus.in_tlast = 0; bus.err_clr = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_start", bus.pe_start, 0);
    check("rst_x_valid", bus.pe_x_tvalid, 0);
    check("rst_out_valid", bus.out_tvalid, 0);
    check("rst_out_last", bus.out_tlast, 0);
    check("rst_base", bus.pe_weight_base, 0);
    check("rst_err_len", bus.err_len, 0);
    check("rst_err_tmo", bus.err_timeout, 0);
    rst = 0;
    @(negedge clk);
    check("rst_in_ready", bus.in_tready, 1);
    for (int i = 0; i < 6; i++) run_row(rows[i], i);
    check("tmo_latency", tmo_rise - (entries.size() > 0 ? entries[0] : 0), TO);
    pulse_clr();
    check("clr_err_tmo", bus.err_timeout, 0);
    clear_log(); no_done = 1; stall = 0; hold_cfg = 0;
    send_vec(NI, NI - 1);
    t = 0;
    while (entries.size() == 0 && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (cyc < (entries.size() > 0 ? entries[0] : 0) + TO - 1 && t < 100) begin @(negedge clk); t++; end
    bus.err_clr = 1;
    @(negedge clk);
    bus.err_clr = 0;
    check("clr_vs_timeout", bus.err_timeout, 0);
    check("clr_timeout_emit", bus.out_tvalid, 1);
    t = 0;
    while (outs_d.size() < 2 && t < 200) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    check("clr_second_tmo", bus.err_timeout, 1);
    check("clr_n_out", outs_d.size(), 2);
    clear_log(); no_done = 0;
    send_vec(NI, NI - 1);
    t = 0;
    while (!(bases.size() == 2 && bus.pe_x_tvalid) && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    check("mid_feed", bus.pe_x_tvalid, 1);
    rst = 1;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_x_valid", bus.pe_x_tvalid, 0);
    check("arst_start", bus.pe_start, 0);
    check("arst_out_valid", bus.out_tvalid, 0);
    check("arst_out_data", bus.out_tdata, 0);
    check("arst_base", bus.pe_weight_base, 0);
    check("arst_err_tmo", bus.err_timeout, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("arst_in_ready", bus.in_tready, 1);
    run_row(rows[0], 6);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
